// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed driver for a NUM_DIGITS-digit seven-segment array.
// A slot counter divides the clock into DIV_CNT-clock digit slots. Each slot
// starts with DEAD_CYC clocks with every select inactive, then drives the
// one-hot select of the current digit. The hex patterns come from a shadow
// copy of the display inputs that is reloaded only at frame boundaries, so a
// frame never mixes old and new values.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           scan enable; low parks the scanner with the display dark
//   data         hex nibble per digit, digit k = data[4k+3:4k]
//   dp           decimal point per digit, 1 = lit
//   blank        1 = digit dark for its whole slot
//   sel          one-hot digit select (polarity per SEL_ACTIVE_LOW)
//   seg          {dp,g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_LOW)
//   digit_idx    index of the digit currently owning seg
//   frame_start  one-clock pulse on the clock the shadow copy is loaded
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int DIV_CNT        = 100000,
  parameter int DEAD_CYC       = 2,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       data,
  input  logic [NUM_DIGITS-1:0]         dp,
  input  logic [NUM_DIGITS-1:0]         blank,
  output logic [NUM_DIGITS-1:0]         sel,
  output logic [7:0]                    seg,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CNT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);

  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_INV}};
  localparam logic [7:0]            SEG_OFF = {8{SEG_INV}};

  // Active-high seven-segment pattern {g,f,e,d,c,b,a} for a hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'h3F;
      4'h1:    p = 7'h06;
      4'h2:    p = 7'h5B;
      4'h3:    p = 7'h4F;
      4'h4:    p = 7'h66;
      4'h5:    p = 7'h6D;
      4'h6:    p = 7'h7D;
      4'h7:    p = 7'h07;
      4'h8:    p = 7'h7F;
      4'h9:    p = 7'h6F;
      4'hA:    p = 7'h77;
      4'hB:    p = 7'h7C;
      4'hC:    p = 7'h39;
      4'hD:    p = 7'h5E;
      4'hE:    p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  logic [CW-1:0]           cnt_reg;
  logic [IW-1:0]           idx_reg;
  logic [4*NUM_DIGITS-1:0] shadow_data_reg;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg;
  logic [NUM_DIGITS-1:0]   shadow_blank_reg;
  logic                    pending_reg;

  // Per-digit view of the shadowed nibbles so the current one can be picked
  // by index.
  logic [3:0] nib [NUM_DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib[gi] = shadow_data_reg[4*gi +: 4];
    end
  endgenerate

  logic in_dead;
  generate
    if (DEAD_CYC == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (cnt_reg < CW'(DEAD_CYC));
    end
  endgenerate

  logic                  cur_blank;
  logic [7:0]            pattern;
  logic                  frame_end;
  logic [NUM_DIGITS-1:0] onehot;
  logic [NUM_DIGITS-1:0] sel_next;
  logic [7:0]            seg_next;

  always_comb begin
    cur_blank = shadow_blank_reg[idx_reg];
    pattern   = {shadow_dp_reg[idx_reg], hex7(nib[idx_reg])};
    frame_end = (cnt_reg == CNT_LAST) && (idx_reg == IDX_LAST);
    onehot    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_reg;
    // Blank keeps the digit dark for the whole slot, dead phase included.
    sel_next  = ((in_dead || cur_blank) ? '0 : onehot) ^ SEL_OFF;
    seg_next  = (cur_blank ? 8'h00 : pattern) ^ SEG_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg          <= '0;
      idx_reg          <= '0;
      shadow_data_reg  <= '0;
      shadow_dp_reg    <= '0;
      shadow_blank_reg <= '0;
      // Coming out of reset counts as a fresh start: the first enabled clock
      // takes a snapshot instead of scanning the cleared shadow.
      pending_reg      <= 1'b1;
      sel              <= SEL_OFF;
      seg              <= SEG_OFF;
      digit_idx        <= '0;
      frame_start      <= 1'b0;
    end else if (!en) begin
      cnt_reg     <= '0;
      idx_reg     <= '0;
      pending_reg <= 1'b1;
      sel         <= SEL_OFF;
      seg         <= SEG_OFF;
      digit_idx   <= '0;
      frame_start <= 1'b0;
    end else if (pending_reg) begin
      // Restart clock: load the snapshot and keep the display dark; the
      // counter is already parked at digit 0, so scanning starts next clock
      // with the new data rather than one clock of stale segments.
      shadow_data_reg  <= data;
      shadow_dp_reg    <= dp;
      shadow_blank_reg <= blank;
      pending_reg      <= 1'b0;
      sel              <= SEL_OFF;
      seg              <= SEG_OFF;
      digit_idx        <= '0;
      frame_start      <= 1'b1;
    end else begin
      sel         <= sel_next;
      seg         <= seg_next;
      digit_idx   <= idx_reg;
      frame_start <= frame_end;
      // The last digit's final clock is decoded from the old shadow above;
      // the new snapshot is first used by digit 0 on the following clock.
      if (frame_end) begin
        shadow_data_reg  <= data;
        shadow_dp_reg    <= dp;
        shadow_blank_reg <= blank;
      end
      if (cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  logic        clk     = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst_n   = 1'b1;
  logic        en      = 1'b0;
  logic [15:0] data    = 16'h0000;
  logic [3:0]  dp      = 4'h0;
  logic [3:0]  blank   = 4'h0;

  logic [3:0] sel,  sel2;
  logic [7:0] seg,  seg2;
  logic [1:0] didx, didx2;
  logic       fs,   fs2;

  int n_checks = 0;
  int n_fail   = 0;

  // Low-active, one dead clock per slot.
  seg_scan_driver #(
    .NUM_DIGITS(4), .DIV_CNT(4), .DEAD_CYC(1),
    .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data), .dp(dp), .blank(blank),
    .sel(sel), .seg(seg), .digit_idx(didx), .frame_start(fs)
  );

  // High-active, no dead time, same stimulus.
  seg_scan_driver #(
    .NUM_DIGITS(4), .DIV_CNT(4), .DEAD_CYC(0),
    .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data), .dp(dp), .blank(blank),
    .sel(sel2), .seg(seg2), .digit_idx(didx2), .frame_start(fs2)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct {
    logic [3:0] sel;
    logic [7:0] seg;
    logic [1:0] didx;
    logic       fs;
    logic [3:0] sel2;
    logic [7:0] seg2;
  } exp_t;

  exp_t sb[$];

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  // Expected outputs for one 16-clock frame scanned from snapshot (d, p, b).
  function automatic void push_frame(input logic [15:0] d, input logic [3:0] p,
                                     input logic [3:0] b);
    exp_t e;
    for (int t = 0; t < 16; t++) begin
      int         dig;
      int         c;
      logic [7:0] pat;
      logic [3:0] oh;
      dig    = t / 4;
      c      = t % 4;
      pat    = {p[dig], seg_ref(d[4*dig +: 4])};
      oh     = 4'b0001 << dig;
      e.sel  = ~((c >= 1 && !b[dig]) ? oh : 4'b0000);
      e.seg  = ~(b[dig] ? 8'h00 : pat);
      e.didx = 2'(dig);
      e.fs   = (t == 15);
      e.sel2 = b[dig] ? 4'b0000 : oh;
      e.seg2 = b[dig] ? 8'h00 : pat;
      sb.push_back(e);
    end
  endfunction

  // Expected outputs for a dark clock (disabled, or snapshot-load clock).
  function automatic void push_idle(input logic f);
    exp_t e;
    e.sel  = 4'hF;
    e.seg  = 8'hFF;
    e.didx = 2'd0;
    e.fs   = f;
    e.sel2 = 4'h0;
    e.seg2 = 8'h00;
    sb.push_back(e);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pop one expectation per clock and compare against both instances.
  task automatic sb_drain(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      tick();
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s[%0d] scoreboard empty: got output, required an expectation", tag, i);
        continue;
      end
      e = sb.pop_front();
      if (sel !== e.sel || seg !== e.seg || didx !== e.didx || fs !== e.fs) begin
        n_fail++;
        $display("FAIL %s[%0d] lowact: sel=%b seg=%h idx=%0d fs=%b required sel=%b seg=%h idx=%0d fs=%b",
                 tag, i, sel, seg, didx, fs, e.sel, e.seg, e.didx, e.fs);
      end else begin
        $display("ok   %s[%0d] lowact sel=%b seg=%h idx=%0d fs=%b", tag, i, sel, seg, didx, fs);
      end
      n_checks++;
      if (sel2 !== e.sel2 || seg2 !== e.seg2 || fs2 !== e.fs) begin
        n_fail++;
        $display("FAIL %s[%0d] highact: sel=%b seg=%h fs=%b required sel=%b seg=%h fs=%b",
                 tag, i, sel2, seg2, fs2, e.sel2, e.seg2, e.fs);
      end
      n_checks++;
      if ($countones(sel) < 3 || $countones(sel2) > 1) begin
        n_fail++;
        $display("FAIL %s[%0d] onehot: sel=%b sel2=%b required at most one active bit",
                 tag, i, sel, sel2);
      end
    end
  endtask

  task automatic test_reset;
    #5 rst_n = 1'b0;
    #1;
    n_checks++;
    if (sel !== 4'hF || seg !== 8'hFF || didx !== 2'd0 || fs !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: sel=%b seg=%h idx=%0d fs=%b required 1111 ff 0 0", sel, seg, didx, fs);
    end else $display("ok   reset_async sel=%b seg=%h", sel, seg);
    n_checks++;
    if (sel2 !== 4'h0 || seg2 !== 8'h00 || fs2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_hi: sel=%b seg=%h fs=%b required 0000 00 0", sel2, seg2, fs2);
    end
    #20;
    n_checks++;
    if (sel !== 4'hF || seg !== 8'hFF || didx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_hold: sel=%b seg=%h idx=%0d required 1111 ff 0", sel, seg, didx);
    end else $display("ok   reset_hold sel=%b seg=%h", sel, seg);
    clk_run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sel !== 4'hF || seg !== 8'hFF || fs !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clocked: sel=%b seg=%h fs=%b required 1111 ff 0", sel, seg, fs);
    end else $display("ok   reset_clocked sel=%b seg=%h", sel, seg);
    rst_n = 1'b1;
    push_idle(1'b0);
    push_idle(1'b0);
    sb_drain(2, "en_low");
  endtask

  task automatic test_basic_scan;
    data = 16'h3210; dp = 4'h0; blank = 4'h0;
    en = 1'b1;
    push_idle(1'b1);
    push_frame(16'h3210, 4'h0, 4'h0);
    push_frame(16'h3210, 4'h0, 4'h0);
    sb_drain(33, "basic");
  endtask

  task automatic test_tear_free;
    push_frame(16'h3210, 4'h0, 4'h0);
    sb_drain(6, "tear_a");           // now inside digit 1's slot
    data = 16'hFFFF;
    sb_drain(10, "tear_b");
    push_frame(16'hFFFF, 4'h0, 4'h0);
    sb_drain(16, "tear_new");
  endtask

  task automatic test_blank_dp;
    push_frame(16'hFFFF, 4'h0, 4'h0);
    sb_drain(3, "bdp_a");
    data = 16'h3210; dp = 4'b0001; blank = 4'b0100;
    sb_drain(13, "bdp_b");
    push_frame(16'h3210, 4'b0001, 4'b0100);
    sb_drain(16, "bdp_new");
  endtask

  task automatic test_enable_toggle;
    push_frame(16'h3210, 4'b0001, 4'b0100);
    sb_drain(10, "en_run");          // inside digit 2's slot
    en = 1'b0;
    sb.delete();
    repeat (3) push_idle(1'b0);
    sb_drain(3, "en_off");
    en = 1'b1;
    push_idle(1'b1);
    push_frame(16'h3210, 4'b0001, 4'b0100);
    sb_drain(17, "en_restart");
  endtask

  task automatic test_reset_midop;
    push_frame(16'h3210, 4'b0001, 4'b0100);
    sb_drain(7, "rst_run");
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (sel !== 4'hF || seg !== 8'hFF || didx !== 2'd0 || fs !== 1'b0 ||
        sel2 !== 4'h0 || seg2 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_midop: sel=%b seg=%h idx=%0d sel2=%b seg2=%h required 1111 ff 0 0000 00",
               sel, seg, didx, sel2, seg2);
    end else $display("ok   reset_midop sel=%b seg=%h", sel, seg);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(1'b1);
    push_frame(16'h3210, 4'b0001, 4'b0100);
    sb_drain(17, "rst_restart");
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_blank_dp();
    test_enable_toggle();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
